vga_sync_monitor: RTL and testbench

Receive-side checker for the VGA signals the MiniAlu top level drives (RGB plus horizontal and vertical sync). It samples the sync and colour lines on the pixel enable and measures line period, hsync width, lines per frame and vsync width. It checks each against the expected 640x480@60 timing, counts lit pixels per frame and flags colour driven during blanking. It is instantiated in test benches and, optionally, on-chip next to the VGA controller to confirm the generator is locked.

---
 rtl/vga_sync_monitor_if.sv | 13 +
 rtl/vga_sync_monitor.sv | 181 ++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_monitor_if.sv
// VGA receive-side bundle: pixel-rate strobe, active-low syncs and 1-bit colour lines.
// The generator drives through master; the monitor samples through slave.
interface vga_sync_monitor_if;
    logic iPixel_Enable;
    logic iHorizontal_Sync;
    logic iVertical_Sync;
    logic iVGA_R;
    logic iVGA_G;
    logic iVGA_B;

    modport master (output iPixel_Enable, iHorizontal_Sync, iVertical_Sync, iVGA_R, iVGA_G, iVGA_B);
    modport slave  (input  iPixel_Enable, iHorizontal_Sync, iVertical_Sync, iVGA_R, iVGA_G, iVGA_B);
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line/frame periods and sync widths,
// counts lit pixels, flags blanking violations and reports lock to the expected timing.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    vga_sync_monitor_if.slave vga,
    output logic [15:0]       oLine_Length,
    output logic [15:0]       oHsync_Width,
    output logic [15:0]       oFrame_Lines,
    output logic [15:0]       oVsync_Width,
    output logic [19:0]       oLit_Pixels,
    output logic              oLocked,
    output logic              oTiming_Error,
    output logic [7:0]        oError_Count
);
    localparam logic [15:0] H_TOTAL_W = 16'(H_TOTAL);
    localparam logic [15:0] H_SYNC_W  = 16'(H_SYNC);
    localparam logic [15:0] V_TOTAL_W = 16'(V_TOTAL);
    localparam logic [15:0] V_SYNC_W  = 16'(V_SYNC);
    localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;
    localparam logic [19:0] PIX_MAX   = 20'hFFFFF;
    localparam logic [7:0]  ERR_MAX   = 8'hFF;

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    state_t state_q;

    logic        hs1_q, vs1_q, hs2_q, vs2_q;
    logic [2:0]  rgb1_q;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [19:0] pixcnt_q, pixcnt_d;
    logic [15:0] line_len_q, hs_width_q, frame_lines_q, vs_width_q;
    logic [19:0] lit_pix_q;
    logic [7:0]  good_q, err_cnt_q;
    logic        dirty_q, skip_len_q, skip_hw_q, first_frame_q, locked_q, err_q;

    logic hfall, hrise, vfall, vrise, lit, blank_err, watchdog, mismatch;

    always_comb begin
        hfall     = hs2_q & ~hs1_q;
        hrise     = ~hs2_q & hs1_q;
        vfall     = vs2_q & ~vs1_q;
        vrise     = ~vs2_q & vs1_q;
        lit       = |rgb1_q;
        blank_err = lit & ~(hs1_q & vs1_q);

        hcnt_d = hcnt_q;
        if (hfall)
            hcnt_d = 16'd1;
        else if (hcnt_q != CNT_MAX)
            hcnt_d = hcnt_q + 16'd1;
        // A line that never ends (hsync stuck) drops the checker back to IDLE silently.
        watchdog = (hcnt_d == CNT_MAX);

        vcnt_d = vcnt_q;
        if (vfall)
            vcnt_d = {15'd0, hfall};
        else if (hfall && (vcnt_q != CNT_MAX))
            vcnt_d = vcnt_q + 16'd1;

        pixcnt_d = pixcnt_q;
        if (vfall)
            pixcnt_d = '0;
        else if (lit && hs1_q && vs1_q && (pixcnt_q != PIX_MAX))
            pixcnt_d = pixcnt_q + 20'd1;

        mismatch = blank_err
                 | (hfall & ~skip_len_q    & (hcnt_q != H_TOTAL_W))
                 | (hrise & ~skip_hw_q     & (hcnt_q != H_SYNC_W))
                 | (vfall & ~first_frame_q & (vcnt_q != V_TOTAL_W))
                 | (vrise &                  (vcnt_q != V_SYNC_W));
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            rgb1_q        <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pixcnt_q      <= '0;
            line_len_q    <= '0;
            hs_width_q    <= '0;
            frame_lines_q <= '0;
            vs_width_q    <= '0;
            lit_pix_q     <= '0;
        end else if (vga.iPixel_Enable) begin
            hs1_q    <= vga.iHorizontal_Sync;
            vs1_q    <= vga.iVertical_Sync;
            rgb1_q   <= {vga.iVGA_R, vga.iVGA_G, vga.iVGA_B};
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            pixcnt_q <= pixcnt_d;
            if (hfall) line_len_q <= hcnt_q;
            if (hrise) hs_width_q <= hcnt_q;
            if (vrise) vs_width_q <= vcnt_q;
            if (vfall) begin
                frame_lines_q <= vcnt_q;
                lit_pix_q     <= pixcnt_q;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= IDLE;
            good_q        <= '0;
            dirty_q       <= 1'b0;
            skip_len_q    <= 1'b0;
            skip_hw_q     <= 1'b0;
            first_frame_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            err_q <= 1'b0;
            if (vga.iPixel_Enable) begin
                if (watchdog) begin
                    state_q  <= IDLE;
                    locked_q <= 1'b0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (vfall) begin
                                state_q       <= ACQUIRE;
                                good_q        <= '0;
                                dirty_q       <= 1'b0;
                                skip_len_q    <= 1'b1;
                                skip_hw_q     <= 1'b1;
                                first_frame_q <= 1'b1;
                            end
                        end
                        default: begin
                            if (hfall) skip_len_q    <= 1'b0;
                            if (hrise) skip_hw_q     <= 1'b0;
                            if (vfall) first_frame_q <= 1'b0;
                            // An error on the frame boundary spoils only the frame it closes.
                            if (mismatch) begin
                                err_q    <= 1'b1;
                                state_q  <= ACQUIRE;
                                locked_q <= 1'b0;
                                good_q   <= '0;
                                dirty_q  <= ~vfall;
                                if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 8'd1;
                            end else if (vfall) begin
                                dirty_q <= 1'b0;
                                if ((state_q == ACQUIRE) && !dirty_q) begin
                                    good_q <= good_q + 8'd1;
                                    if ((good_q + 8'd1) >= LOCK_W) begin
                                        state_q  <= LOCKED;
                                        locked_q <= 1'b1;
                                    end
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign oLine_Length  = line_len_q;
    assign oHsync_Width  = hs_width_q;
    assign oFrame_Lines  = frame_lines_q;
    assign oVsync_Width  = vs_width_q;
    assign oLit_Pixels   = lit_pix_q;
    assign oLocked       = locked_q;
    assign oTiming_Error = err_q;
    assign oError_Count  = err_cnt_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a miniature 20x6 raster; an event/timestamp
// reference model is compared every clock, plus hand-computed expectations at milestones.
module tb_vga_sync_monitor;
    localparam int H_TOTAL = 20, H_SYNC = 3, V_TOTAL = 6, V_SYNC = 2, LOCK_FRAMES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_monitor_if vif();

    logic [15:0] oLine_Length, oHsync_Width, oFrame_Lines, oVsync_Width;
    logic [19:0] oLit_Pixels;
    logic        oLocked, oTiming_Error;
    logic [7:0]  oError_Count;

    vga_sync_monitor #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .Clock(clk), .Reset(rst_n), .vga(vif),
        .oLine_Length(oLine_Length), .oHsync_Width(oHsync_Width),
        .oFrame_Lines(oFrame_Lines), .oVsync_Width(oVsync_Width),
        .oLit_Pixels(oLit_Pixels), .oLocked(oLocked),
        .oTiming_Error(oTiming_Error), .oError_Count(oError_Count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    // Reference model: samples are kept as a short history; measurements are taken
    // from enable timestamps and running event totals rather than per-signal counters.
    logic [4:0]  hist[$];
    int unsigned en_idx, last_hf, hf_tot, hf_at_v, lit_tot, lit_at_v;
    int          mode, good;
    bit          dirty, sk_len, sk_hw, first_fr, mdl_started = 1'b0;
    logic [15:0] m_len, m_hw, m_fl, m_vw;
    logic [19:0] m_lit;
    logic        m_lock, m_err;
    logic [7:0]  m_cnt;

    always @(posedge clk) begin : model
        logic [4:0]  cur, s_new, s_old;
        bit          hf, hr, vf, vr, bad, wd, lit_ok;
        int unsigned hcnt, hnext, vcnt, pcnt;
        mdl_started = 1'b1;
        m_err = 1'b0;
        if (!rst_n) begin
            hist.delete();
            hist.push_back(5'b11000);
            hist.push_back(5'b11000);
            en_idx = 0; last_hf = 0; hf_tot = 0; hf_at_v = 0; lit_tot = 0; lit_at_v = 0;
            mode = 0; good = 0; dirty = 0; sk_len = 0; sk_hw = 0; first_fr = 0;
            m_len = 0; m_hw = 0; m_fl = 0; m_vw = 0; m_lit = 0; m_lock = 0; m_cnt = 0;
        end else if (vif.iPixel_Enable) begin
            cur   = {vif.iHorizontal_Sync, vif.iVertical_Sync, vif.iVGA_R, vif.iVGA_G, vif.iVGA_B};
            s_old = hist[0];
            s_new = hist[1];
            hf = s_old[4] && !s_new[4];
            hr = !s_old[4] && s_new[4];
            vf = s_old[3] && !s_new[3];
            vr = !s_old[3] && s_new[3];
            hcnt  = en_idx - last_hf;          if (hcnt > 65535) hcnt = 65535;
            hnext = hf ? 1 : hcnt + 1;         if (hnext > 65535) hnext = 65535;
            vcnt  = hf_tot - hf_at_v;          if (vcnt > 65535) vcnt = 65535;
            pcnt  = lit_tot - lit_at_v;        if (pcnt > 20'hFFFFF) pcnt = 20'hFFFFF;
            lit_ok = (s_new[2:0] != 3'b000) && s_new[4] && s_new[3];
            if (hf) m_len = 16'(hcnt);
            if (hr) m_hw  = 16'(hcnt);
            if (vr) m_vw  = 16'(vcnt);
            if (vf) begin m_fl = 16'(vcnt); m_lit = 20'(pcnt); end
            bad = ((s_new[2:0] != 3'b000) && !(s_new[4] && s_new[3]))
               || (hf && !sk_len   && hcnt != H_TOTAL)
               || (hr && !sk_hw    && hcnt != H_SYNC)
               || (vf && !first_fr && vcnt != V_TOTAL)
               || (vr && vcnt != V_SYNC);
            wd = (hnext == 65535);
            if (wd) mode = 0;
            else if (mode == 0) begin
                if (vf) begin mode = 1; good = 0; dirty = 0; sk_len = 1; sk_hw = 1; first_fr = 1; end
            end else begin
                if (hf) sk_len = 0;
                if (hr) sk_hw = 0;
                if (vf) first_fr = 0;
                if (bad) begin
                    m_err = 1'b1;
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                    mode = 1; good = 0; dirty = !vf;
                end else if (vf) begin
                    if (mode == 1 && !dirty) begin
                        good++;
                        if (good >= LOCK_FRAMES) mode = 2;
                    end
                    dirty = 0;
                end
            end
            m_lock = (mode == 2);
            if (hf) begin last_hf = en_idx; hf_tot++; end
            if (lit_ok) lit_tot++;
            if (vf) begin hf_at_v = hf_tot - (hf ? 1 : 0); lit_at_v = lit_tot; end
            en_idx++;
            hist.push_back(cur);
            void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (mdl_started) begin
            n_checks++;
            if (oTiming_Error === 1'b1) pulse_cnt++;
            if ({oLine_Length, oHsync_Width, oFrame_Lines, oVsync_Width, oLit_Pixels,
                 oLocked, oTiming_Error, oError_Count} !==
                {m_len, m_hw, m_fl, m_vw, m_lit, m_lock, m_err, m_cnt}) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t got len=%0d hw=%0d fl=%0d vw=%0d lit=%0d lock=%0b err=%0b cnt=%0d want len=%0d hw=%0d fl=%0d vw=%0d lit=%0d lock=%0b err=%0b cnt=%0d",
                         $time, oLine_Length, oHsync_Width, oFrame_Lines, oVsync_Width, oLit_Pixels,
                         oLocked, oTiming_Error, oError_Count,
                         m_len, m_hw, m_fl, m_vw, m_lit, m_lock, m_err, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_len"},  int'(oLine_Length), 0);
        chk({tag, "_hw"},   int'(oHsync_Width), 0);
        chk({tag, "_fl"},   int'(oFrame_Lines), 0);
        chk({tag, "_vw"},   int'(oVsync_Width), 0);
        chk({tag, "_lit"},  int'(oLit_Pixels), 0);
        chk({tag, "_lock"}, int'(oLocked), 0);
        chk({tag, "_err"},  int'(oTiming_Error), 0);
        chk({tag, "_cnt"},  int'(oError_Count), 0);
    endtask

    task automatic chk_ideal(input string tag);
        chk({tag, "_len"}, int'(oLine_Length), 20);
        chk({tag, "_hw"},  int'(oHsync_Width), 3);
        chk({tag, "_fl"},  int'(oFrame_Lines), 6);
        chk({tag, "_vw"},  int'(oVsync_Width), 2);
        chk({tag, "_lit"}, int'(oLit_Pixels), 16);   // 4 lit pixels on each of the 4 lines outside vsync
    endtask

    // One pixel: enable high for one clock, low for the next.
    task automatic pix(input bit h, input bit v, input bit r, input bit g, input bit b);
        @(negedge clk);
        vif.iPixel_Enable = 1'b1;
        vif.iHorizontal_Sync = h; vif.iVertical_Sync = v;
        vif.iVGA_R = r; vif.iVGA_G = g; vif.iVGA_B = b;
        @(negedge clk);
        vif.iPixel_Enable = 1'b0;
    endtask

    // Lines first..last of a frame; vsync low on lines 0..V_SYNC-1, R lit on pixels 5..8 elsewhere.
    task automatic send_lines(input int first, input int last, input int long_l, input int g_l);
        for (int l = first; l <= last; l++) begin
            for (int p = 0; p < ((l == long_l) ? H_TOTAL + 1 : H_TOTAL); p++)
                pix(p >= H_SYNC, l >= V_SYNC, (l >= V_SYNC) && p >= 5 && p < 9, (l == g_l) && p == 1, 1'b0);
        end
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) send_lines(0, V_TOTAL - 1, -1, -1);
    endtask

    task automatic stall(input int n);
        @(negedge clk);
        vif.iPixel_Enable = 1'b1;
        vif.iHorizontal_Sync = 1'b1; vif.iVertical_Sync = 1'b1;
        vif.iVGA_R = 1'b0; vif.iVGA_G = 1'b0; vif.iVGA_B = 1'b0;
        repeat (n) @(negedge clk);
        vif.iPixel_Enable = 1'b0;
    endtask

    initial begin
        vif.iPixel_Enable = 1'b0;
        vif.iHorizontal_Sync = 1'b1; vif.iVertical_Sync = 1'b1;
        vif.iVGA_R = 1'b0; vif.iVGA_G = 1'b0; vif.iVGA_B = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Ideal raster: lock on the third vsync falling edge.
        frames(2);
        chk("lock_after_2_frames", int'(oLocked), 0);
        frames(1);
        chk("lock_after_3_frames", int'(oLocked), 1);
        frames(1);
        chk_ideal("ideal");
        chk("ideal_cnt", int'(oError_Count), 0);

        // One 21-enable line.
        send_lines(0, V_TOTAL - 1, 3, -1);
        chk("long_cnt", int'(oError_Count), 1);
        chk("long_pulses", pulse_cnt, 1);
        chk("long_lock", int'(oLocked), 0);
        frames(2);
        chk("long_relock_early", int'(oLocked), 0);
        frames(1);
        chk("long_relock", int'(oLocked), 1);
        chk_ideal("after_long");

        // Green driven during hsync.
        send_lines(0, V_TOTAL - 1, -1, 3);
        chk("blank_cnt", int'(oError_Count), 2);
        chk("blank_pulses", pulse_cnt, 2);
        chk("blank_lock", int'(oLocked), 0);
        frames(3);
        chk("blank_relock", int'(oLocked), 1);

        // hsync stuck high past the 16-bit counter range.
        stall(65540);
        chk("wd_lock", int'(oLocked), 0);
        chk("wd_cnt", int'(oError_Count), 2);
        chk("wd_pulses", pulse_cnt, 2);
        frames(2);
        chk("wd_relock_early", int'(oLocked), 0);
        frames(1);
        chk("wd_relock", int'(oLocked), 1);
        chk_ideal("after_wd");

        // Reset in the middle of a frame.
        send_lines(0, 2, -1, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        send_lines(3, V_TOTAL - 1, -1, -1);
        frames(2);
        chk("rst_relock_early", int'(oLocked), 0);
        frames(1);
        chk("rst_relock", int'(oLocked), 1);
        chk("rst_fl", int'(oFrame_Lines), 6);
        chk("rst_vw", int'(oVsync_Width), 2);
        chk("rst_cnt", int'(oError_Count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
